// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bus for the segmented carry-lookahead adder.
// Operands and sum are numbered [W:1], bit 1 being the LSB.
interface cla_seq_adder_if #(
   parameter int W = 64
);
   logic         in_valid;
   logic         in_ready;
   logic [W:1]   a;
   logic [W:1]   b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W:1]   sum;
   logic         cout;
   logic         busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/cla_seq_adder.sv
// W-bit adder built from one SIZE-bit two-level carry-lookahead slice,
// reused for SEGS consecutive cycles with the carry held in a register.

// Sum-of-products lookahead over V bits: carries into each bit plus group G/P.
module cla_seq_adder_grp #(
   parameter int V = 4
) (
   input  logic [V-1:0] g,
   input  logic [V-1:0] p,
   input  logic         ci,
   output logic [V-1:0] c,
   output logic         gg,
   output logic         gp
);
   logic acc, pp;

   always_comb begin
      c   = '0;
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = 0; j < V; j++) begin
         acc = 1'b0;
         pp  = 1'b1;
         for (int m = j - 1; m >= 0; m--) begin
            acc = acc | (pp & g[m]);
            pp  = pp & p[m];
         end
         c[j] = acc | (pp & ci);
      end
      acc = 1'b0;
      pp  = 1'b1;
      for (int m = V - 1; m >= 0; m--) begin
         acc = acc | (pp & g[m]);
         pp  = pp & p[m];
      end
      gg = acc;
      gp = pp;
   end
endmodule

module cla_seq_adder_slice #(
   parameter int SIZE    = 16,
   parameter int VALENCY = 4
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            ci,
   output logic [SIZE-1:0] s,
   output logic            co
);
   localparam int NG = SIZE / VALENCY;

   logic [SIZE-1:0] g, p, c;
   logic [NG-1:0]   grp_g, grp_p, grp_c;
   logic            top_g, top_p;

   assign g = a & b;
   assign p = a ^ b;

   for (genvar i = 0; i < NG; i++) begin : g_grp
      cla_seq_adder_grp #(.V(VALENCY)) u_grp (
         .g  (g[i*VALENCY +: VALENCY]),
         .p  (p[i*VALENCY +: VALENCY]),
         .ci (grp_c[i]),
         .c  (c[i*VALENCY +: VALENCY]),
         .gg (grp_g[i]),
         .gp (grp_p[i])
      );
   end

   // Second level: group carries resolved by lookahead over group G/P.
   cla_seq_adder_grp #(.V(NG)) u_top (
      .g  (grp_g),
      .p  (grp_p),
      .ci (ci),
      .c  (grp_c),
      .gg (top_g),
      .gp (top_p)
   );

   assign s  = p ^ c;
   assign co = top_g | (top_p & ci);
endmodule

module cla_seq_adder #(
   parameter int SIZE    = 16,
   parameter int SEGS    = 4,
   parameter int VALENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   cla_seq_adder_if.slave    bus
);
   localparam int W  = SIZE * SEGS;
   localparam int KW = (SEGS > 1) ? $clog2(SEGS) : 1;
   localparam logic [KW-1:0] KLAST = KW'(SEGS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic            carry;
   logic [W:1]      areg, breg;
   logic [W:1]      sum_q;
   logic            cout_q, out_valid_q, busy_q;
   logic [SIZE-1:0] sa, sb, ss;
   logic            sco;
   logic            xfer;
   int              lo;

   assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign xfer          = bus.in_valid && bus.in_ready;

   always_comb begin
      lo = int'(k) * SIZE + 1;
      sa = areg[lo +: SIZE];
      sb = breg[lo +: SIZE];
   end

   cla_seq_adder_slice #(.SIZE(SIZE), .VALENCY(VALENCY)) u_slice (
      .a  (sa),
      .b  (sb),
      .ci (carry),
      .s  (ss),
      .co (sco)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         k           <= '0;
         carry       <= 1'b0;
         areg        <= '0;
         breg        <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (clr) begin
         // Abort wins over transfer and completion; result registers keep their value.
         state       <= IDLE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (xfer) begin
         areg        <= bus.a;
         breg        <= bus.b;
         carry       <= bus.cin;
         k           <= '0;
         state       <= RUN;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               sum_q[lo +: SIZE] <= ss;
               carry             <= sco;
               if (k == KLAST) begin
                  cout_q      <= sco;
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder at SIZE=16, SEGS=4 (W=64).
module tb_cla_seq_adder;
   localparam int W = 64;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   int   cyc = 0;
   int   nchk = 0;
   int   nfail = 0;
   logic [W:0] exp_q[$];

   cla_seq_adder_if #(.W(W)) bus ();

   cla_seq_adder #(.SIZE(16), .SEGS(4), .VALENCY(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      nchk++;
      if (obs !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
      return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
         else chk("result", {bus.cout, bus.sum}, exp_q.pop_front());
      end
   end

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       input bit push, input bit keep, output int tcyc);
      bit done = 0;
      bus.a = av; bus.b = bv; bus.cin = ci; bus.in_valid = 1'b1;
      tcyc = -1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            if (push) exp_q.push_back(model(av, bv, ci));
            @(posedge clk); #1;
            tcyc = cyc;
            done = 1;
         end
      end
      if (!done) chk("xfer_timeout", 0, 1);
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("drain", W'(exp_q.size()), 0);
   endtask

   initial begin
      int t0, t1, t2, lat, ovs;
      logic [W-1:0] ra, rb, prev_sum;
      logic [W:0]   e;
      logic         rc, prev_cout;
      logic [15:0]  seg0;

      rst_n = 1'b0; clr = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      #3;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_sum_cout", {bus.cout, bus.sum}, 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Full carry ripple and latency
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1, 0, t0);
      lat = 0;
      for (int n = 1; n <= 10 && lat == 0; n++) begin
         @(posedge clk); #1;
         if (bus.out_valid) lat = n;
      end
      chk("latency", W'(lat), 4);
      drain();
      chk("ripple_const", {bus.cout, bus.sum}, {1'b1, 64'h0});

      send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1, 0, t0);
      drain();
      chk("segbound_const", {bus.cout, bus.sum}, {1'b0, 64'h0001_0000_0001_0001});

      send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 0, t0);
      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1, 0, t0);
      for (int i = 0; i < 6; i++) begin
         ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
         send(ra, rb, rc, 1, 0, t0);
      end
      drain();

      // Backpressure in DONE
      bus.out_ready = 1'b0;
      ra = 64'h1234_5678_9ABC_DEF0; rb = 64'hFEDC_BA98_7654_3210;
      e = model(ra, rb, 1'b1);
      send(ra, rb, 1'b1, 1, 0, t0);
      for (int n = 0; n < 20 && !bus.out_valid; n++) begin @(posedge clk); #1; end
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_result", {bus.cout, bus.sum}, e);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_ov", bus.out_valid, 0);
      chk("bp_idle_busy", bus.busy, 0);

      // Back-to-back with in_valid held high
      send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1, 1, t0);
      send(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1, 1, 1, t1);
      send(64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_0000_0000, 1'b1, 1, 0, t2);
      chk("b2b_period1", W'(t1 - t0), 5);
      chk("b2b_period2", W'(t2 - t1), 5);
      drain();

      // Reset at k=2
      send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 0, 0, t0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_sum_cout", {bus.cout, bus.sum}, 0);
      chk("midrst_ov", bus.out_valid, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      ovs = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (bus.out_valid) ovs++;
      end
      chk("postrst_no_ov", W'(ovs), 0);
      chk("postrst_in_ready", bus.in_ready, 1);

      // CLR at k=1 with in_valid high
      ra = 64'h0F0F_0F0F_0F0F_0F0F; rb = 64'h7070_7070_7070_7070;
      e = model(ra, rb, 1'b0);
      prev_sum = e[W-1:0]; prev_cout = e[W];
      send(ra, rb, 1'b0, 1, 0, t0);
      drain();
      ra = 64'h0000_0000_0000_FFFF; rb = 64'h0000_0000_0000_1234;
      seg0 = ra[15:0] + rb[15:0] + 16'd1;
      send(ra, rb, 1'b1, 0, 0, t0);
      @(posedge clk); #1;
      clr = 1'b1; bus.in_valid = 1'b1;
      bus.a = 64'h1; bus.b = 64'h1; bus.cin = 1'b0;
      @(posedge clk); #1;
      clr = 1'b0; bus.in_valid = 1'b0;
      chk("clr_busy", bus.busy, 0);
      chk("clr_in_ready", bus.in_ready, 1);
      ovs = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (bus.out_valid) ovs++;
      end
      chk("clr_no_ov", W'(ovs), 0);
      chk("clr_sum_cout", {bus.cout, bus.sum}, {prev_cout, prev_sum[63:16], seg0});
      chk("queue_empty", W'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
